// File: rtl/gpio_event_ctrl.sv
// GPIO input bank: per-pin synchroniser, optional debounce, edge detection, sticky status and irq.
// Define GPIO_EVT_DEBOUNCE_EN to build the per-pin debounce counters; otherwise pins pass straight through.
module gpio_event_ctrl #(
  parameter int PIN_NUM     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIN_NUM-1:0]     gpio_in,
  input  logic [2*PIN_NUM-1:0]   cfg_mode,
  input  logic [PIN_NUM-1:0]     cfg_irq_en,
  input  logic [DEB_CNT_W-1:0]   cfg_deb_len,
  input  logic                   clr_valid,
  input  logic [PIN_NUM-1:0]     clr_mask,
  output logic                   clr_ready,
  output logic [PIN_NUM-1:0]     pin_state,
  output logic [PIN_NUM-1:0]     evt_status,
  output logic [PIN_NUM-1:0]     evt_overflow,
  output logic                   irq
);

  logic [PIN_NUM-1:0] sync_q [SYNC_STAGES];
  logic [PIN_NUM-1:0] sync_w;
  logic [PIN_NUM-1:0] pin_q, pin_d;
  logic [PIN_NUM-1:0] sts_q, sts_d;
  logic [PIN_NUM-1:0] ovf_q, ovf_d;
  logic [PIN_NUM-1:0] rise_en_w, fall_en_w;
  logic [PIN_NUM-1:0] evt_w, clr_w;
  logic               irq_q, irq_d;
  logic               rdy_q;

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef GPIO_EVT_DEBOUNCE_EN
  logic [DEB_CNT_W-1:0] cnt_q [PIN_NUM];
  logic [DEB_CNT_W-1:0] cnt_d [PIN_NUM];

  function automatic logic [DEB_CNT_W-1:0] sat_inc(input logic [DEB_CNT_W-1:0] v);
    return (&v) ? v : v + DEB_CNT_W'(1);
  endfunction

  // A differing level is accepted once it has persisted past the threshold; any agreement restarts the count.
  always_comb begin
    pin_d = pin_q;
    for (int i = 0; i < PIN_NUM; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != pin_q[i]) begin
        if (cnt_q[i] >= cfg_deb_len) pin_d[i] = sync_w[i];
        else                         cnt_d[i] = sat_inc(cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIN_NUM; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < PIN_NUM; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic unused_deb_len;
  assign unused_deb_len = ^cfg_deb_len;
  assign pin_d = sync_w;
`endif

  always_comb begin
    rise_en_w = '0;
    fall_en_w = '0;
    for (int i = 0; i < PIN_NUM; i++) begin
      rise_en_w[i] = cfg_mode[2*i];
      fall_en_w[i] = cfg_mode[2*i+1];
    end
  end

  // Events are taken from the pin_state transition itself so status lands on the same edge.
  always_comb begin
    evt_w = (pin_d & ~pin_q & rise_en_w) | (~pin_d & pin_q & fall_en_w);
    clr_w = {PIN_NUM{clr_valid & rdy_q}} & clr_mask;
    sts_d = (sts_q & ~clr_w) | evt_w;
    ovf_d = (ovf_q | (evt_w & sts_q)) & ~clr_w;
    irq_d = |(sts_q & cfg_irq_en);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pin_q <= '0;
      sts_q <= '0;
      ovf_q <= '0;
      irq_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      pin_q <= pin_d;
      sts_q <= sts_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      rdy_q <= 1'b1;
    end
  end

  assign clr_ready    = rdy_q;
  assign pin_state    = pin_q;
  assign evt_status   = sts_q;
  assign evt_overflow = ovf_q;
  assign irq          = irq_q;

endmodule
